// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipelined control unit: instruction fields,
// ALU codes and the layout of the control words carried down the pipe.
package pipe_ctrl_pkg;

  localparam int OPCODE_W   = 6;
  localparam int ALU_CODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  localparam logic [OPCODE_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OPCODE_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OPCODE_W-1:0] FN_AND = 6'b100100;
  localparam logic [OPCODE_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OPCODE_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALU_CODE_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_CODE_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT = 3'b111;

  // Selects how the ALU decoder derives its code; 2'b11 is never issued.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // Control bits still needed once the instruction leaves Decode.
  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_write;
    logic [ALU_CODE_W-1:0] alu_ctrl;
    logic                  alu_src;
    logic                  reg_dst;
  } ctrl_e_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } ctrl_m_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } ctrl_w_t;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps ALUOp and the funct field to an ALU code. Only the
// funct-driven path can be illegal.
module alu_decoder
  import pipe_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0]   funct,
  input  alu_op_e               alu_op,
  output logic [ALU_CODE_W-1:0] alu_ctrl,
  output logic                  illegal
);

  // Combinational ALU code selection.
  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: begin
            alu_ctrl = ALU_AND;
            illegal  = 1'b1;
          end
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined main/ALU control unit. Decodes the Decode-stage instruction,
// resolves branch/jump there, and carries the remaining control bits through
// the E, M and W registers so each stage sees its own instruction's controls.
module pipe_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int OP_W   = OPCODE_W,
  parameter int ALUC_W = ALU_CODE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   Opcode,
  input  logic [OP_W-1:0]   Funct,
  input  logic              branch_boolean,
  input  logic              stall_d,
  input  logic              flush_e,
  output logic              PCSrc,
  output logic              JumpC,
  output logic              RegDstE,
  output logic              ALUSrcB,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic              MemWrite,
  output logic              MemToReg,
  output logic              RegWriteW,
  output logic              RegWriteE,
  output logic              RegWriteM,
  output logic              MemToRegE,
  output logic              illegal_op
);

  ctrl_e_t                 word_d;
  ctrl_e_t                 ctrl_e;
  ctrl_m_t                 ctrl_m;
  ctrl_w_t                 ctrl_w;
  alu_op_e                 alu_op;
  logic [ALU_CODE_W-1:0]   alu_code;
  logic                    funct_illegal;
  logic                    op_illegal;
  logic                    branch_d;
  logic                    jump_d;
  logic                    illegal_d;

  alu_decoder u_alu_decoder (
    .funct    (Funct),
    .alu_op   (alu_op),
    .alu_ctrl (alu_code),
    .illegal  (funct_illegal)
  );

  // Main decoder: control word, branch/jump flags and illegal detection.
  always_comb begin
    word_d     = '0;
    alu_op     = ALUOP_ADD;
    branch_d   = 1'b0;
    jump_d     = 1'b0;
    op_illegal = 1'b0;
    case (Opcode)
      OP_RTYPE: begin
        alu_op           = ALUOP_FUNCT;
        word_d.reg_write = 1'b1;
        word_d.reg_dst   = 1'b1;
        word_d.alu_ctrl  = alu_code;
      end
      OP_LW: begin
        word_d.reg_write  = 1'b1;
        word_d.mem_to_reg = 1'b1;
        word_d.alu_src    = 1'b1;
        word_d.alu_ctrl   = alu_code;
      end
      OP_SW: begin
        word_d.mem_write = 1'b1;
        word_d.alu_src   = 1'b1;
        word_d.alu_ctrl  = alu_code;
      end
      OP_BEQ: begin
        alu_op          = ALUOP_SUB;
        branch_d        = 1'b1;
        word_d.alu_ctrl = alu_code;
      end
      OP_ADDI: begin
        word_d.reg_write = 1'b1;
        word_d.alu_src   = 1'b1;
        word_d.alu_ctrl  = alu_code;
      end
      OP_J: jump_d = 1'b1;
      default: op_illegal = 1'b1;
    endcase
    // An unknown funct degrades the R-type to a NOP rather than a partial write.
    if (funct_illegal) word_d = '0;
  end

  assign illegal_d = op_illegal | funct_illegal;

  // Decode-stage redirects; deliberately not gated by reset.
  always_comb begin
    PCSrc = branch_d & branch_boolean & ~stall_d;
    JumpC = jump_d & ~stall_d;
  end

  // E register: reset beats flush, flush inserts a bubble, stall never holds.
  always_ff @(posedge clk) begin
    if (!reset)       ctrl_e <= '0;
    else if (flush_e) ctrl_e <= '0;
    else              ctrl_e <= word_d;
  end

  // M and W registers advance every cycle unless reset kills them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_m <= '0;
      ctrl_w <= '0;
    end else begin
      ctrl_m <= '{reg_write: ctrl_e.reg_write, mem_to_reg: ctrl_e.mem_to_reg,
                  mem_write: ctrl_e.mem_write};
      ctrl_w <= '{reg_write: ctrl_m.reg_write, mem_to_reg: ctrl_m.mem_to_reg};
    end
  end

  // Sticky illegal flag; a stalled decode is not a real issue so it is ignored.
  always_ff @(posedge clk) begin
    if (!reset)                       illegal_op <= 1'b0;
    else if (illegal_d && !stall_d)   illegal_op <= 1'b1;
  end

  assign RegWriteE   = ctrl_e.reg_write;
  assign MemToRegE   = ctrl_e.mem_to_reg;
  assign ALUControlE = ctrl_e.alu_ctrl;
  assign ALUSrcB     = ctrl_e.alu_src;
  assign RegDstE     = ctrl_e.reg_dst;
  assign MemWrite    = ctrl_m.mem_write;
  assign RegWriteM   = ctrl_m.reg_write;
  assign RegWriteW   = ctrl_w.reg_write;
  assign MemToReg    = ctrl_w.mem_to_reg;

endmodule

// File: tb/tb_pipe_controller.sv
// Testbench for pipe_controller: directed test-plan sequences followed by
// randomized traffic, all checked against an instruction-history model.
module tb_pipe_controller;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       branch_boolean;
  logic       stall_d;
  logic       flush_e;
  logic       PCSrc, JumpC, RegDstE, ALUSrcB;
  logic [2:0] ALUControlE;
  logic       MemWrite, MemToReg, RegWriteW, RegWriteE, RegWriteM, MemToRegE;
  logic       illegal_op;

  pipe_controller dut (
    .clk            (clk),
    .reset          (reset),
    .Opcode         (Opcode),
    .Funct          (Funct),
    .branch_boolean (branch_boolean),
    .stall_d        (stall_d),
    .flush_e        (flush_e),
    .PCSrc          (PCSrc),
    .JumpC          (JumpC),
    .RegDstE        (RegDstE),
    .ALUSrcB        (ALUSrcB),
    .ALUControlE    (ALUControlE),
    .MemWrite       (MemWrite),
    .MemToReg       (MemToReg),
    .RegWriteW      (RegWriteW),
    .RegWriteE      (RegWriteE),
    .RegWriteM      (RegWriteM),
    .MemToRegE      (MemToRegE),
    .illegal_op     (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic       mtr;
    logic       mw;
    logic [2:0] alu;
    logic       src;
    logic       dst;
  } ew_t;

  localparam int HMAX = 4096;

  ew_t  e_hist [HMAX];
  bit   rst_hist [HMAX];
  int   k;
  bit   ill_exp;
  int   n_tests;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
    end
  endtask

  // Instruction semantics as a lookup table (decimal opcode/funct values).
  function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                     output ew_t w, output bit br, output bit jmp,
                                     output bit ill);
    w = '0; br = 0; jmp = 0; ill = 0;
    case (op)
      6'd0: begin
        case (fn)
          6'd32: w = '{1, 0, 0, 3'd2, 0, 1};
          6'd34: w = '{1, 0, 0, 3'd6, 0, 1};
          6'd36: w = '{1, 0, 0, 3'd0, 0, 1};
          6'd37: w = '{1, 0, 0, 3'd1, 0, 1};
          6'd42: w = '{1, 0, 0, 3'd7, 0, 1};
          default: ill = 1;
        endcase
      end
      6'd35: w = '{1, 1, 0, 3'd2, 1, 0};
      6'd43: w = '{0, 0, 1, 3'd2, 1, 0};
      6'd4:  begin w = '{0, 0, 0, 3'd6, 0, 0}; br = 1; end
      6'd8:  w = '{1, 0, 0, 3'd2, 1, 0};
      6'd2:  jmp = 1;
      default: ill = 1;
    endcase
  endfunction

  // One Decode slot: drive inputs, check the redirects, clock, check stages.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic bb,
                      input logic st, input logic fl, input logic rs);
    ew_t w, em, ew;
    bit  br, jmp, ill;
    Opcode = op; Funct = fn; branch_boolean = bb; stall_d = st; flush_e = fl; reset = rs;
    #1;
    ref_decode(op, fn, w, br, jmp, ill);
    chk("pcsrc", PCSrc, br & bb & ~st);
    chk("jumpc", JumpC, jmp & ~st);
    @(posedge clk);
    e_hist[k]   = (!rs || fl) ? ew_t'('0) : w;
    rst_hist[k] = !rs;
    if (!rs) ill_exp = 0;
    else if (ill && !st) ill_exp = 1;
    // A word in stage s came from the slot s edges back, unless a reset fell in between.
    em = (k >= 1 && !rst_hist[k]) ? e_hist[k-1] : ew_t'('0);
    ew = (k >= 2 && !rst_hist[k] && !rst_hist[k-1]) ? e_hist[k-2] : ew_t'('0);
    #1;
    chk("regwrite_e", RegWriteE, e_hist[k].rw);
    chk("memtoreg_e", MemToRegE, e_hist[k].mtr);
    chk("aluctrl_e", ALUControlE, e_hist[k].alu);
    chk("alusrc_e", ALUSrcB, e_hist[k].src);
    chk("regdst_e", RegDstE, e_hist[k].dst);
    chk("memwrite_m", MemWrite, em.mw);
    chk("regwrite_m", RegWriteM, em.rw);
    chk("regwrite_w", RegWriteW, ew.rw);
    chk("memtoreg_w", MemToReg, ew.mtr);
    chk("illegal", illegal_op, ill_exp);
    k++;
  endtask

  // Filler slot: beq not taken, writes nothing.
  task automatic fill(input int n);
    for (int i = 0; i < n; i++) step(6'd4, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    k = 0; ill_exp = 0; n_tests = 0; n_fail = 0;
    Opcode = '0; Funct = '0; branch_boolean = 0; stall_d = 0; flush_e = 0; reset = 0;
    @(posedge clk);
    #1;

    // Reset held two cycles with lw on the opcode.
    step(6'd35, 6'd0, 0, 0, 0, 0);
    step(6'd35, 6'd0, 0, 0, 0, 0);
    chk("reset_memtoreg_e", MemToRegE, 1'b0);
    chk("reset_illegal", illegal_op, 1'b0);

    // lw through the pipe.
    step(6'd35, 6'd0, 0, 0, 0, 1);
    chk("lw_memtoreg_e_n1", MemToRegE, 1'b1);
    fill(2);
    chk("lw_regwrite_w_n3", RegWriteW, 1'b1);
    chk("lw_memtoreg_w_n3", MemToReg, 1'b1);
    fill(1);

    // R-type sub.
    step(6'd0, 6'd34, 0, 0, 0, 1);
    chk("sub_aluctrl_n1", ALUControlE, 3'b110);
    fill(3);

    // sw then addi back to back.
    step(6'd43, 6'd0, 0, 0, 0, 1);
    step(6'd8, 6'd0, 0, 0, 0, 1);
    chk("sw_memwrite_n2", MemWrite, 1'b1);
    fill(4);

    // Branch / jump resolution, with and without stall.
    step(6'd4, 6'd0, 1, 0, 0, 1);
    step(6'd4, 6'd0, 1, 1, 1, 1);
    step(6'd2, 6'd0, 0, 0, 0, 1);
    step(6'd2, 6'd0, 0, 1, 1, 1);

    // lw followed by a flushed lw slot.
    step(6'd35, 6'd0, 0, 0, 0, 1);
    step(6'd35, 6'd0, 0, 0, 1, 1);
    fill(4);

    // Illegal under stall is ignored, then a real illegal sticks.
    step(6'd63, 6'd0, 0, 1, 1, 1);
    step(6'd63, 6'd0, 0, 0, 0, 1);
    chk("illegal_set", illegal_op, 1'b1);
    step(6'd0, 6'd17, 0, 0, 0, 1);
    step(6'd35, 6'd0, 0, 0, 0, 1);
    step(6'd8, 6'd0, 0, 0, 0, 1);
    chk("illegal_sticky", illegal_op, 1'b1);

    // Reset with a sw in flight: MemWrite must never assert.
    step(6'd43, 6'd0, 0, 0, 0, 1);
    step(6'd4, 6'd0, 0, 0, 0, 0);
    chk("reset_kills_sw", MemWrite, 1'b0);
    fill(3);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [5:0] op, fn;
      logic bb, st, fl, rs;
      case ($urandom_range(0, 7))
        0: op = 6'd0; 1: op = 6'd35; 2: op = 6'd43; 3: op = 6'd4;
        4: op = 6'd8; 5: op = 6'd2;  6: op = 6'd0;
        default: op = 6'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: fn = 6'd32; 1: fn = 6'd34; 2: fn = 6'd36; 3: fn = 6'd37; 4: fn = 6'd42;
        default: fn = 6'($urandom);
      endcase
      bb = 1'($urandom);
      st = ($urandom_range(0, 5) == 0);
      fl = st ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 59) != 0);
      step(op, fn, bb, st, fl, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
